dma_controller: RTL and testbench
=================================

// Module: dma_controller
// PURPOSE
//  Bus-side DMA engine for the memory port shared by the CPU cache and an external device.
//  On begin_dma it latches target_address/length, requests the bus with br and waits for bg.
//  It streams device words into memory one at a time, yielding the bus between bursts.
//  On completion it pulses interrupt so the CPU knows the transfer is done.
// PARAMETERS
//  WORD_SIZE  16  data/address width (shared `WORD_SIZE define)
//  BURST_LEN  4   words written per bus tenure before br is released (power of 2, >=1)
// PORTS
//  clk             in   1          single clock, all state updates on posedge
//  reset           in   1          synchronous, active-high; sampled on posedge clk
//  begin_dma       in   1          start pulse; sampled only in IDLE
//  target_address  in   WORD_SIZE  base memory address, latched with begin_dma
//  length          in   WORD_SIZE  number of words, latched with begin_dma
//  bg              in   1          bus grant from CPU
//  br              out  1          bus request to CPU
//  dev_valid       in   1          device word valid
//  dev_data        in   WORD_SIZE  device word
//  dev_ready       out  1          controller accepts a device word this cycle
//  mem_ack         in   1          memory completed the current write (1-cycle pulse)
//  mem_write       out  1          memory write strobe, held until mem_ack
//  mem_address     out  WORD_SIZE  write address = base + count (mod 2^WORD_SIZE)
//  mem_data        out  WORD_SIZE  buffered device word
//  interrupt       out  1          1-cycle completion pulse
//  busy            out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; br, dev_ready, mem_write, interrupt, busy = 0; mem_address, mem_data,
//   count, base, len = 0. Reset mid-transfer aborts immediately; no interrupt is generated.
//  States: IDLE, REQ, XFER, YIELD, DONE.
//  IDLE: begin_dma=1 -> latch base/len, count=0; len==0 -> DONE, else -> REQ. busy=1 next cycle.
//  REQ: br=1. bg sampled 1 -> XFER. No other action.
//  XFER: br=1. Single-word buffer.
//   - buffer empty and bg=1 -> dev_ready=1; dev_valid&dev_ready -> buffer word,
//     mem_write=1, mem_address=base+count from next cycle.
//   - mem_write stays high with address/data stable until mem_ack sampled 1; on that edge
//     mem_write=0, count+=1, buffer empty.
//   - bg=0 while in XFER: dev_ready=0, no new write starts; a write already in flight holds
//     until mem_ack. Resume when bg returns.
//   - after ack: count==len -> DONE; else count%BURST_LEN==0 -> YIELD; else stay.
//  YIELD: br=0 for >=1 cycle; leave when bg sampled 0 -> REQ.
//  DONE: br=0, interrupt=1 for exactly one cycle -> IDLE.
//  begin_dma outside IDLE is ignored; it is not queued.
//  mem_ack outside a pending write is ignored.
//  Arithmetic: count is WORD_SIZE bits; address is base+count truncated, so it wraps.
//   len=0xFFFF is legal.
//  Latency: begin_dma edge -> br high 1 cycle later; bg sampled -> dev_ready in the next cycle.
// STRUCTURE
//  Shared package/header: `WORD_SIZE and the state encodings DMA_IDLE..DMA_DONE (3-bit localparams).
//  Single module, no sub-module: the FSM, the word buffer and the counter are too small
//   to justify a split.
// TESTING
//  1 base=0x000b, len=12, bg follows br by 2 cycles, mem_ack 3 cycles after mem_write ->
//    12 writes to 0x000b..0x0016 with data as sent; br falls twice between bursts; one interrupt.
//  2 len=0 -> interrupt pulses 2 cycles after begin_dma; br, mem_write never asserted.
//  3 base=0xfffe, len=4 -> addresses fffe, ffff, 0000, 0001; interrupt once.
//  4 second begin_dma (base=0x0100) during scenario 1 -> ignored; all writes stay at the
//    first base.
//  5 bg dropped for 5 cycles mid-burst with a write pending -> that write completes on
//    mem_ack; no dev_ready and no new mem_write until bg returns; final count still 12.
//  6 reset after the 5th ack -> next cycle all outputs 0 and state IDLE; no interrupt;
//    a new begin_dma starts cleanly.

Source files
------------

// File: rtl/dma_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller_pkg
// Description : Shared definitions for the DMA controller. Provides the
//               default data/address width and the 3-bit state encodings
//               used by the controller FSM.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package dma_controller_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] DMA_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] DMA_REQ   = 3'd1;
    localparam logic [c_STATE_W-1:0] DMA_XFER  = 3'd2;
    localparam logic [c_STATE_W-1:0] DMA_YIELD = 3'd3;
    localparam logic [c_STATE_W-1:0] DMA_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller
// Description : Bus-side DMA engine. Latches a base address and word count on
//               begin_dma, requests the shared memory bus (br/bg), streams
//               device words into memory one at a time through a single-word
//               buffer, yields the bus every BURST_LEN words and pulses
//               interrupt on completion.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               begin_dma             - start pulse (honoured only when idle)
//               target_address/length - transfer base and word count
//               bg / br               - bus grant in / bus request out
//               dev_valid/dev_data    - device word stream in
//               dev_ready             - device word accepted this cycle
//               mem_ack               - memory write completion pulse
//               mem_write/mem_address/mem_data - memory write port
//               interrupt             - one-cycle completion pulse
//               busy                  - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 begin_dma,
    input  logic [WORD_SIZE-1:0] target_address,
    input  logic [WORD_SIZE-1:0] length,
    input  logic                 bg,
    output logic                 br,
    input  logic                 dev_valid,
    input  logic [WORD_SIZE-1:0] dev_data,
    output logic                 dev_ready,
    input  logic                 mem_ack,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 interrupt,
    output logic                 busy
);

    // BURST_LEN is a power of two, so the burst boundary test is a mask.
    localparam logic [WORD_SIZE-1:0] c_BURST_MASK = WORD_SIZE'(BURST_LEN - 1);
    localparam logic [WORD_SIZE-1:0] c_ONE        = WORD_SIZE'(1);

    logic [c_STATE_W-1:0] r_state;
    logic [WORD_SIZE-1:0] r_base;
    logic [WORD_SIZE-1:0] r_len;
    logic [WORD_SIZE-1:0] r_count;
    logic [WORD_SIZE-1:0] r_mem_address;
    logic [WORD_SIZE-1:0] r_mem_data;
    logic                 r_br;
    logic                 r_dev_ready;
    logic                 r_mem_write;
    logic                 r_interrupt;
    logic                 r_busy;

    logic [WORD_SIZE-1:0] w_count_inc;
    logic                 w_burst_end;

    assign w_count_inc = r_count + c_ONE;
    assign w_burst_end = (w_count_inc & c_BURST_MASK) == '0;

    // The word buffer is full exactly while mem_write is asserted, so
    // r_mem_write doubles as the buffer-occupied flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= DMA_IDLE;
            r_base        <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_br          <= 1'b0;
            r_dev_ready   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_interrupt   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_interrupt <= 1'b0;
            case (r_state)
                DMA_IDLE: begin
                    if (begin_dma) begin
                        r_base  <= target_address;
                        r_len   <= length;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        if (length == '0) begin
                            r_state <= DMA_DONE;
                        end else begin
                            r_state <= DMA_REQ;
                            r_br    <= 1'b1;
                        end
                    end
                end

                DMA_REQ: begin
                    if (bg) begin
                        r_state     <= DMA_XFER;
                        r_dev_ready <= 1'b1;
                    end
                end

                DMA_XFER: begin
                    if (r_mem_write) begin
                        // A write in flight completes regardless of bg.
                        if (mem_ack) begin
                            r_mem_write <= 1'b0;
                            r_count     <= w_count_inc;
                            if (w_count_inc == r_len) begin
                                r_state     <= DMA_DONE;
                                r_br        <= 1'b0;
                                r_dev_ready <= 1'b0;
                            end else if (w_burst_end) begin
                                r_state     <= DMA_YIELD;
                                r_br        <= 1'b0;
                                r_dev_ready <= 1'b0;
                            end else begin
                                r_dev_ready <= bg;
                            end
                        end
                    end else if (r_dev_ready && dev_valid) begin
                        r_mem_data    <= dev_data;
                        r_mem_address <= r_base + r_count;
                        r_mem_write   <= 1'b1;
                        r_dev_ready   <= 1'b0;
                    end else begin
                        r_dev_ready <= bg;
                    end
                end

                DMA_YIELD: begin
                    // Wait for the CPU to take the bus back before re-requesting.
                    if (!bg) begin
                        r_state <= DMA_REQ;
                        r_br    <= 1'b1;
                    end
                end

                DMA_DONE: begin
                    r_interrupt <= 1'b1;
                    r_busy      <= 1'b0;
                    r_br        <= 1'b0;
                    r_state     <= DMA_IDLE;
                end

                default: begin
                    r_state     <= DMA_IDLE;
                    r_br        <= 1'b0;
                    r_dev_ready <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign br          = r_br;
    assign dev_ready   = r_dev_ready;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign interrupt   = r_interrupt;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_controller
// Description : Self-checking bench for dma_controller. A table of transfer
//               records (directed corner cases followed by randomized ones)
//               is applied one by one against bus, device and memory models;
//               each write is checked against the address/data the transfer
//               rules dictate, and per-transfer totals against the table.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_dma_controller;

    localparam int c_BURST = 4;

    logic        clk;
    logic        reset;
    logic        begin_dma;
    logic [15:0] target_address;
    logic [15:0] length;
    logic        bg;
    logic        br;
    logic        dev_valid;
    logic [15:0] dev_data;
    logic        dev_ready;
    logic        mem_ack;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        interrupt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dma_controller #(
        .WORD_SIZE (16),
        .BURST_LEN (c_BURST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .begin_dma      (begin_dma),
        .target_address (target_address),
        .length         (length),
        .bg             (bg),
        .br             (br),
        .dev_valid      (dev_valid),
        .dev_data       (dev_data),
        .dev_ready      (dev_ready),
        .mem_ack        (mem_ack),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .interrupt      (interrupt),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        int          bg_dly;     // bg follows br by this many cycles (1..4)
        int          ack_dly;    // cycles mem_write is seen before mem_ack
        int          vpct;       // device valid probability, percent
        int          drop_at;    // drop bg 5 cycles when write #drop_at+1 starts
        int          reset_at;   // assert reset after this many acks
        bit          second;     // fire an extra begin_dma mid-transfer
        bit          spur;       // spurious mem_ack while no write pending
        int          exp_writes;
        int          exp_falls;  // br falling edges (one per burst)
        int          exp_irqs;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every row starts and ends at a negedge with the DUT idle.
    task automatic run_row(input vec_t v);
        logic [15:0] sent[$];
        logic [3:0]  brh;
        logic        p_br, p_bg, p_mw, p_ack, p_dr, p_dv;
        logic [15:0] p_addr, p_data, ea;
        int          nw, falls, irqs, acks, ackw, drop, cyc;
        bit          first_dr, sent2, finished, aborted;
        nw = 0; falls = 0; irqs = 0; acks = 0; ackw = 0; drop = 0;
        first_dr = 0; sent2 = 0; finished = 0; aborted = 0; brh = '0;

        target_address = v.base;
        length         = v.len;
        begin_dma      = 1'b1;
        bg             = 1'b0;
        dev_valid      = 1'b0;
        mem_ack        = 1'b0;
        @(negedge clk);
        begin_dma = 1'b0;

        if (v.len == 16'd0) begin
            check("zlen_cycle1", {br, mem_write, busy, interrupt}, 4'b0010);
            @(negedge clk);
            check("zlen_irq", {br, mem_write, busy, interrupt}, 4'b0001);
            @(negedge clk);
            check("zlen_after", {br, mem_write, busy, interrupt}, 4'b0000);
            return;
        end

        check("br_after_begin", {br, busy}, 2'b11);
        p_br = br; p_bg = 1'b0; p_mw = 1'b0; p_ack = 1'b0;
        p_dr = 1'b0; p_dv = 1'b0; p_addr = '0; p_data = '0;

        for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (p_br && !br) falls++;
            if (!p_bg) check("dr_without_bg", dev_ready, 0);
            if (p_bg && !first_dr) begin
                check("bg_to_dev_ready", dev_ready, 1);
                first_dr = 1;
            end
            if (p_dr && p_dv) check("handshake_to_write", mem_write, 1);
            if (p_mw && !p_ack)
                check("write_hold", {mem_write, mem_address, mem_data}, {1'b1, p_addr, p_data});
            if (p_mw && p_ack) begin
                check("ack_clears_write", mem_write, 0);
                acks++;
            end
            if (!p_mw && mem_write) begin
                ea = v.base + 16'(nw);
                check("write_addr", mem_address, ea);
                if (nw < sent.size()) check("write_data", mem_data, sent[nw]);
                else check("write_source", sent.size(), nw + 1);
                nw++;
                if (v.drop_at >= 0 && nw == v.drop_at + 1) drop = 5;
            end
            if (interrupt) begin
                irqs++;
                check("irq_idle", {busy, br, mem_write}, 3'b000);
                finished = 1;
            end
            if (!finished && v.reset_at >= 0 && acks == v.reset_at) begin
                reset = 1'b1; bg = 1'b0; dev_valid = 1'b0; mem_ack = 1'b0;
                @(negedge clk);
                check("reset_abort",
                      {br, dev_ready, mem_write, interrupt, busy, mem_address, mem_data}, 0);
                reset = 1'b0;
                finished = 1;
                aborted = 1;
            end
            if (!finished) begin
                brh = {brh[2:0], br};
                bg = brh[v.bg_dly-1];
                if (drop > 0) begin
                    bg = 1'b0;
                    drop--;
                end
                if (mem_write) begin
                    ackw++;
                    mem_ack = (ackw >= v.ack_dly);
                    if (mem_ack) ackw = 0;
                end else begin
                    ackw = 0;
                    mem_ack = v.spur && ($urandom_range(0, 3) == 0);
                end
                dev_valid = ($urandom_range(1, 100) <= v.vpct);
                dev_data  = 16'($urandom);
                begin_dma = 1'b0;
                if (v.second && nw == 3 && !sent2) begin
                    begin_dma      = 1'b1;
                    target_address = 16'h0100;
                    length         = 16'd7;
                    sent2          = 1;
                end
                if (dev_ready && dev_valid) sent.push_back(dev_data);
                p_br = br; p_bg = bg; p_mw = mem_write; p_ack = mem_ack;
                p_dr = dev_ready; p_dv = dev_valid; p_addr = mem_address; p_data = mem_data;
                @(negedge clk);
            end
        end

        check("finished_in_budget", finished, 1);
        if (finished && !aborted) begin
            bg = 1'b0; dev_valid = 1'b0; mem_ack = 1'b0; begin_dma = 1'b0;
            @(negedge clk);
            check("irq_single_cycle", {interrupt, busy}, 2'b00);
        end
        check("row_writes", nw, v.exp_writes);
        check("row_br_falls", falls, v.exp_falls);
        check("row_interrupts", irqs, v.exp_irqs);
    endtask

    initial begin
        vec_t r;
        int   len;

        //       base      len    bgd ackd vpct drop rst 2nd spur wr fl irq
        vt.push_back('{16'h000b, 16'd12, 2, 3, 100, -1, -1, 0, 0, 12, 3, 1});
        vt.push_back('{16'h1234, 16'd0,  2, 3, 100, -1, -1, 0, 0,  0, 0, 1});
        vt.push_back('{16'hfffe, 16'd4,  2, 3, 100, -1, -1, 0, 0,  4, 1, 1});
        vt.push_back('{16'h000b, 16'd12, 2, 3, 100, -1, -1, 1, 0, 12, 3, 1});
        vt.push_back('{16'h0200, 16'd12, 2, 3, 100,  5, -1, 0, 0, 12, 3, 1});
        vt.push_back('{16'h0300, 16'd12, 2, 3, 100, -1,  5, 0, 0,  5, 1, 0});
        vt.push_back('{16'h0040, 16'd5,  1, 1,  60, -1, -1, 0, 1,  5, 2, 1});
        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(1, 20);
            r.base       = 16'($urandom);
            r.len        = 16'(len);
            r.bg_dly     = $urandom_range(1, 3);
            r.ack_dly    = $urandom_range(1, 4);
            r.vpct       = $urandom_range(30, 100);
            r.drop_at    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            r.reset_at   = -1;
            r.second     = ($urandom_range(0, 3) == 0);
            r.spur       = 1'b1;
            r.exp_writes = len;
            r.exp_falls  = (len + c_BURST - 1) / c_BURST;
            r.exp_irqs   = 1;
            vt.push_back(r);
        end

        reset = 1'b1; begin_dma = 1'b0; target_address = '0; length = '0;
        bg = 1'b0; dev_valid = 1'b0; dev_data = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",
              {br, dev_ready, mem_write, interrupt, busy, mem_address, mem_data}, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_row(vt[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
